// File: rtl/reg_file_banked_pkg.sv
// Shared types and helpers for the banked register file and its clear engine.
// Sizes derived from the default parameters; instances size themselves via the helpers.
package reg_file_banked_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int DEF_REG_BIT_CNT  = 3;
  localparam int DEF_BANK_BIT_CNT = 1;
  localparam int NREGS            = 1 << DEF_REG_BIT_CNT;
  localparam int NBANKS           = 1 << DEF_BANK_BIT_CNT;

  function automatic int nregs(input int reg_bits);
    return 1 << reg_bits;
  endfunction

  function automatic int nbanks(input int bank_bits);
    return 1 << bank_bits;
  endfunction

endpackage

// File: rtl/reg_file_banked_if.sv
// Bus between the writeback/ALU side (master) and the banked register file (slave).
interface reg_file_banked_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int REG_BIT_CNT  = 3,
  parameter int BANK_BIT_CNT = 1
);
  logic                    we;
  logic [REG_BIT_CNT-1:0]  wsel;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [REG_BIT_CNT-1:0]  rsel_a;
  logic [REG_BIT_CNT-1:0]  rsel_b;
  logic [DATA_WIDTH-1:0]   rdata_a;
  logic [DATA_WIDTH-1:0]   rdata_b;
  logic                    bank_sw;
  logic [BANK_BIT_CNT-1:0] bank_next;
  logic [BANK_BIT_CNT-1:0] active_bank;
  logic                    clr_start;
  logic [BANK_BIT_CNT-1:0] clr_bank;
  logic                    busy;
  logic                    clr_done;
  logic                    wr_drop;

  modport master (
    output we, wsel, wdata, rsel_a, rsel_b, bank_sw, bank_next, clr_start, clr_bank,
    input  rdata_a, rdata_b, active_bank, busy, clr_done, wr_drop
  );

  modport slave (
    input  we, wsel, wdata, rsel_a, rsel_b, bank_sw, bank_next, clr_start, clr_bank,
    output rdata_a, rdata_b, active_bank, busy, clr_done, wr_drop
  );
endinterface

// File: rtl/reg_file_banked_clr_ctrl.sv
// Bank clear engine: walks one register per cycle through the latched bank,
// then pulses clr_done in the first idle cycle.
module reg_file_clr_ctrl
  import reg_file_banked_pkg::*;
#(
  parameter int REG_BIT_CNT  = 3,
  parameter int BANK_BIT_CNT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr_start,
  input  logic [BANK_BIT_CNT-1:0] i_clr_bank,
  output logic                    o_busy,
  output logic                    o_clr_done,
  output logic                    o_clr_we,
  output logic [REG_BIT_CNT-1:0]  o_clr_reg,
  output logic [BANK_BIT_CNT-1:0] o_clr_bank
);

  localparam logic [REG_BIT_CNT-1:0] LAST_REG = '1;

  clr_state_e              r_state, w_state_next;
  logic [REG_BIT_CNT-1:0]  r_cnt, w_cnt_next;
  logic [BANK_BIT_CNT-1:0] r_bank, w_bank_next;
  logic                    r_done, w_done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bank  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bank  <= w_bank_next;
      r_done  <= w_done_next;
    end
  end

  // A start request seen while clearing is dropped, not queued.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bank_next  = r_bank;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_clr_start) begin
          w_state_next = CLEAR;
          w_bank_next  = i_clr_bank;
          w_cnt_next   = '0;
        end
      end
      CLEAR: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == LAST_REG) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
          w_cnt_next   = '0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_busy     = (r_state == CLEAR);
  assign o_clr_we   = (r_state == CLEAR);
  assign o_clr_reg  = r_cnt;
  assign o_clr_bank = r_bank;
  assign o_clr_done = r_done;

endmodule

// File: rtl/reg_file_banked.sv
// Multi-bank register file: one write port, two combinational read ports with
// optional bypass and hardwired-zero r0, bank switching and a background bank clear.
module reg_file_banked
  import reg_file_banked_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int REG_BIT_CNT  = 3,
  parameter int BANK_BIT_CNT = 1,
  parameter int ZERO_REG     = 1,
  parameter int BYPASS       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_file_banked_if.slave  bus
);

  localparam int ENTRIES = nbanks(BANK_BIT_CNT) * nregs(REG_BIT_CNT);
  localparam int ADDR_W  = BANK_BIT_CNT + REG_BIT_CNT;

  logic [DATA_WIDTH-1:0]   r_mem [ENTRIES];
  logic [BANK_BIT_CNT-1:0] r_active_bank;
  logic                    r_wr_drop;

  logic                    w_busy;
  logic                    w_clr_done;
  logic                    w_clr_we;
  logic [REG_BIT_CNT-1:0]  w_clr_reg;
  logic [BANK_BIT_CNT-1:0] w_clr_bank;
  logic                    w_clr_hit;
  logic                    w_zero_wr;
  logic                    w_wr_acc;
  logic [ADDR_W-1:0]       w_wr_addr;
  logic [ADDR_W-1:0]       w_clr_addr;

  reg_file_clr_ctrl #(
    .REG_BIT_CNT (REG_BIT_CNT),
    .BANK_BIT_CNT(BANK_BIT_CNT)
  ) u_clr_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr_start(bus.clr_start),
    .i_clr_bank (bus.clr_bank),
    .o_busy     (w_busy),
    .o_clr_done (w_clr_done),
    .o_clr_we   (w_clr_we),
    .o_clr_reg  (w_clr_reg),
    .o_clr_bank (w_clr_bank)
  );

  // User writes to the bank being cleared are refused, so the two write
  // sources below never target the same entry.
  assign w_clr_hit  = w_busy && (r_active_bank == w_clr_bank);
  assign w_zero_wr  = (ZERO_REG != 0) && (bus.wsel == '0);
  assign w_wr_acc   = bus.we && !w_clr_hit && !w_zero_wr;
  assign w_wr_addr  = {r_active_bank, bus.wsel};
  assign w_clr_addr = {w_clr_bank, w_clr_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_acc) begin
        r_mem[w_wr_addr] <= bus.wdata;
      end
      if (w_clr_we) begin
        r_mem[w_clr_addr] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_bank <= '0;
      r_wr_drop     <= 1'b0;
    end else begin
      if (bus.bank_sw) begin
        r_active_bank <= bus.bank_next;
      end
      r_wr_drop <= bus.we && w_clr_hit && !w_zero_wr;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [REG_BIT_CNT-1:0] w_sel;
      logic [DATA_WIDTH-1:0]  w_rd;

      assign w_sel = (gi == 0) ? bus.rsel_a : bus.rsel_b;

      // Zero-register check comes last so it also masks any bypass.
      always_comb begin
        w_rd = r_mem[{r_active_bank, w_sel}];
        if ((BYPASS != 0) && w_wr_acc && (bus.wsel == w_sel)) begin
          w_rd = bus.wdata;
        end
        if ((ZERO_REG != 0) && (w_sel == '0)) begin
          w_rd = '0;
        end
      end
    end
  endgenerate

  assign bus.rdata_a     = g_rd[0].w_rd;
  assign bus.rdata_b     = g_rd[1].w_rd;
  assign bus.active_bank = r_active_bank;
  assign bus.busy        = w_busy;
  assign bus.clr_done    = w_clr_done;
  assign bus.wr_drop     = r_wr_drop;

endmodule

// File: tb/tb_reg_file_banked.sv
// Directed, table-driven bench for reg_file_banked (8-bit, 8 regs, 2 banks).
module tb_reg_file_banked;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   busy_cnt;
  int   done_cnt;
  int   drop_cnt;
  logic mon_en;

  reg_file_banked_if #(.DATA_WIDTH(8), .REG_BIT_CNT(3), .BANK_BIT_CNT(1)) bus ();

  reg_file_banked #(
    .DATA_WIDTH(8), .REG_BIT_CNT(3), .BANK_BIT_CNT(1), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] wsel;
    logic [7:0] wdata;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       sw;
    logic       nb;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       ebank;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input logic [2:0] a, input logic [2:0] b,
                          input logic [7:0] ea, input logic [7:0] eb, input string tag);
    bus.rsel_a = a;
    bus.rsel_b = b;
    @(negedge clk);
    chk($sformatf("%s_a_r%0d", tag, a), {24'd0, bus.rdata_a}, {24'd0, ea});
    chk($sformatf("%s_b_r%0d", tag, b), {24'd0, bus.rdata_b}, {24'd0, eb});
    cyc();
  endtask

  task automatic write(input logic [2:0] sel, input logic [7:0] d);
    bus.we = 1'b1; bus.wsel = sel; bus.wdata = d;
    cyc();
    bus.we = 1'b0;
  endtask

  task automatic switch_bank(input logic b);
    bus.bank_sw = 1'b1; bus.bank_next = b;
    cyc();
    bus.bank_sw = 1'b0;
  endtask

  task automatic clear_counts();
    busy_cnt = 0; done_cnt = 0; drop_cnt = 0;
  endtask

  // Counts status pulses once per cycle; clr_done must coincide with busy low.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.busy)    busy_cnt++;
      if (bus.wr_drop) drop_cnt++;
      if (bus.clr_done) begin
        done_cnt++;
        chk("done_with_busy_low", {31'd0, bus.busy}, 32'd0);
      end
    end
  end

  initial begin
    checks = 0; errors = 0; mon_en = 1'b0;
    clear_counts();
    rst_n = 1'b0;
    bus.we = 1'b0; bus.wsel = '0; bus.wdata = '0;
    bus.rsel_a = '0; bus.rsel_b = '0;
    bus.bank_sw = 1'b0; bus.bank_next = '0;
    bus.clr_start = 1'b0; bus.clr_bank = '0;

    //               we   wsel  wdata  ra    rb    sw    nb    ea     eb     bank
    vecs[0] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 3'd3, 8'h5A, 3'd3, 3'd3, 1'b0, 1'b0, 8'h5A, 8'h5A, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd0, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 3'd0, 8'h11, 3'd0, 3'd3, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0};
    vecs[4] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 3'd2, 8'hAA, 3'd2, 3'd3, 1'b1, 1'b1, 8'hAA, 8'h5A, 1'b0};
    vecs[6] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[7] = '{1'b1, 3'd2, 8'h33, 3'd2, 3'd1, 1'b0, 1'b0, 8'h33, 8'h00, 1'b1};
    vecs[8] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 1'b1, 1'b0, 8'h33, 8'h33, 1'b1};
    vecs[9] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 1'b0, 1'b0, 8'hAA, 8'h5A, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_active_bank", {31'd0, bus.active_bank}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_clr_done", {31'd0, bus.clr_done}, 32'd0);
    chk("rst_wr_drop", {31'd0, bus.wr_drop}, 32'd0);
    cyc();
    for (int i = 0; i < 8; i++) rd_check(3'(i), 3'(7 - i), 8'h00, 8'h00, "rst");

    // Bypass, zero register and bank switching
    for (int i = 0; i < 10; i++) begin
      bus.we = vecs[i].we; bus.wsel = vecs[i].wsel; bus.wdata = vecs[i].wdata;
      bus.rsel_a = vecs[i].ra; bus.rsel_b = vecs[i].rb;
      bus.bank_sw = vecs[i].sw; bus.bank_next = vecs[i].nb;
      @(negedge clk);
      chk($sformatf("vec%0d_rdata_a", i), {24'd0, bus.rdata_a}, {24'd0, vecs[i].ea});
      chk($sformatf("vec%0d_rdata_b", i), {24'd0, bus.rdata_b}, {24'd0, vecs[i].eb});
      chk($sformatf("vec%0d_bank", i), {31'd0, bus.active_bank}, {31'd0, vecs[i].ebank});
      cyc();
    end
    bus.we = 1'b0; bus.bank_sw = 1'b0;

    // Fill bank 1 with 0xFF, then clear it from bank 0 while writing bank 0
    switch_bank(1'b1);
    for (int i = 1; i < 8; i++) write(3'(i), 8'hFF);
    rd_check(3'd7, 3'd1, 8'hFF, 8'hFF, "fill");
    switch_bank(1'b0);
    mon_en = 1'b1;
    clear_counts();
    bus.clr_start = 1'b1; bus.clr_bank = 1'b1;
    cyc();
    bus.clr_start = 1'b0;
    cyc();
    cyc();
    write(3'd4, 8'h44);
    repeat (14) cyc();
    chk("clr1_busy_cycles", busy_cnt, 32'd8);
    chk("clr1_done_pulses", done_cnt, 32'd1);
    chk("clr1_wr_drops", drop_cnt, 32'd0);
    rd_check(3'd4, 3'd3, 8'h44, 8'h5A, "clr1_bank0");
    switch_bank(1'b1);
    for (int i = 0; i < 8; i++) rd_check(3'(i), 3'(7 - i), 8'h00, 8'h00, "clr1_bank1");

    // Clear the active bank; blocked write mid-clear and an ignored restart
    write(3'd5, 8'h77);
    clear_counts();
    bus.clr_start = 1'b1; bus.clr_bank = 1'b1;
    cyc();
    bus.clr_start = 1'b0;
    cyc();
    cyc();
    bus.we = 1'b1; bus.wsel = 3'd5; bus.wdata = 8'h99;
    bus.clr_start = 1'b1; bus.clr_bank = 1'b0;
    bus.rsel_a = 3'd5;
    @(negedge clk);
    chk("clr2_blocked_read_old", {24'd0, bus.rdata_a}, 32'h77);
    cyc();
    bus.we = 1'b0; bus.clr_start = 1'b0;
    @(negedge clk);
    chk("clr2_wr_drop", {31'd0, bus.wr_drop}, 32'd1);
    cyc();
    repeat (12) cyc();
    chk("clr2_busy_cycles", busy_cnt, 32'd8);
    chk("clr2_done_pulses", done_cnt, 32'd1);
    chk("clr2_wr_drops", drop_cnt, 32'd1);
    rd_check(3'd5, 3'd7, 8'h00, 8'h00, "clr2_bank1");
    switch_bank(1'b0);
    rd_check(3'd4, 3'd3, 8'h44, 8'h5A, "clr2_bank0_kept");

    // Reset in the middle of a clear of the inactive bank
    switch_bank(1'b1);
    clear_counts();
    bus.clr_start = 1'b1; bus.clr_bank = 1'b0;
    cyc();
    bus.clr_start = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_active_bank", {31'd0, bus.active_bank}, 32'd0);
    chk("arst_clr_done", {31'd0, bus.clr_done}, 32'd0);
    cyc();
    rst_n = 1'b1;
    repeat (12) cyc();
    chk("arst_busy_cycles", busy_cnt, 32'd3);
    chk("arst_done_pulses", done_cnt, 32'd0);
    for (int i = 0; i < 8; i++) rd_check(3'(i), 3'(7 - i), 8'h00, 8'h00, "arst_bank0");
    switch_bank(1'b1);
    for (int i = 0; i < 8; i++) rd_check(3'(i), 3'(7 - i), 8'h00, 8'h00, "arst_bank1");
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_banked.md
# reg_file_banked

Parametrised multi-bank register file: two combinational read ports, one write port, optional write-to-read bypass, and an optional hardwired-zero register 0. Holds `1<<BANK_BIT_CNT` banks, one active at a time, for fast context switching. A sequential clear engine zeroes one bank at one register per cycle. It sits between the accumulator/writeback path and the ALU operand inputs, replacing the single-port register file.

## Interface
Parameters:
- DATA_WIDTH, 8, register width
- REG_BIT_CNT, 3, register address bits (registers per bank = 1<<REG_BIT_CNT)
- BANK_BIT_CNT, 1, bank address bits (≥1)
- ZERO_REG, 1, 1 = register 0 of every bank reads 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- we  in  1  write enable
- wsel  in  REG_BIT_CNT  write register index (active bank)
- wdata  in  DATA_WIDTH  write data (accumulator)
- rsel_a, rsel_b  in  REG_BIT_CNT  read indices
- rdata_a, rdata_b  out  DATA_WIDTH  read data to ALU
- bank_sw  in  1  bank switch request
- bank_next  in  BANK_BIT_CNT  bank to activate
- active_bank  out  BANK_BIT_CNT  current bank
- clr_start  in  1  start bank clear
- clr_bank  in  BANK_BIT_CNT  bank to clear
- busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse, clear finished
- wr_drop  out  1  one-cycle pulse, previous-cycle write was blocked

## Operation
- Reset: every register of every bank = 0; active_bank = 0; busy = 0; clr_done = 0; wr_drop = 0; clear FSM in IDLE, counter 0.
- Write accepted when we=1 and not (busy and active_bank == clear bank latched at start). Accepted write stores wdata to reg[active_bank][wsel] at posedge.
- ZERO_REG=1 and wsel=0: write is discarded silently (no wr_drop).
- Write blocked by clear: no storage; wr_drop=1 for the following cycle.
- Reads are combinational from active_bank. With ZERO_REG=1, index 0 returns 0. With BYPASS=1, if the write is accepted and wsel == rsel_x (nonzero when ZERO_REG=1), rdata_x = wdata. Otherwise rdata_x is the stored value.
- Bank switch: bank_sw=1 loads bank_next into active_bank at posedge. A write in the same cycle goes to the old bank. bank_sw is honoured regardless of busy.
- Clear FSM states:
  - IDLE: clr_start=1 → CLEAR; latch clr_bank; counter=0.
  - CLEAR: each cycle writes 0 to reg[latched][counter] and increments counter. When counter reaches (1<<REG_BIT_CNT)-1, that entry is cleared and the FSM goes to IDLE, with clr_done=1 in the next cycle.
  - clr_start while busy is ignored.
- Clear and user write never collide: a user write to the bank under clear is blocked. Other banks are written normally in parallel.
- Reads of the bank under clear return 0 for entries already cleared and old contents for the rest.
- Asynchronous reset mid-clear aborts it: FSM to IDLE, all state zeroed, no clr_done.

## Timing
- Read latency 0 cycles (combinational). Write visible on read ports the cycle after the edge, or in the same cycle via bypass.
- busy rises in the cycle after the clr_start edge and stays high for exactly 1<<REG_BIT_CNT cycles.
- clr_done is high in the cycle busy falls.
- wr_drop is registered: high exactly one cycle after a blocked write.
- active_bank updates one cycle after bank_sw.

## Structure
- Shared package: clear-FSM state enum (IDLE, CLEAR) and derived constants NREGS = 1<<REG_BIT_CNT and NBANKS = 1<<BANK_BIT_CNT.
- Storage is a flat array indexed by {bank, reg}.
- One sub-module: reg_file_clr_ctrl (FSM + counter + busy/clr_done). Read muxing and bypass stay in the top.

## Test plan
- Reset then read all indices, both ports → all 0; active_bank=0; busy=0.
- Write 0x5A to r3, then read r3 on port A and r3 on port B in the same cycle → both 0x5A (bypass). Next cycle stored value is 0x5A. Write 0x11 to r0 → r0 reads 0.
- Write 0xAA to r2 in bank 0, bank_sw to 1, read r2 → 0. Write 0x33 to r2, switch back → r2 = 0xAA.
- clr_start on bank 1 while active_bank=0 and bank 1 is full of 0xFF → busy for 8 cycles. The bank-0 write during the clear succeeds. clr_done pulses once. Bank 1 reads all 0.
- clr_start on the active bank, write r5 mid-clear → wr_drop pulses next cycle and r5 ends at 0. A second clr_start while busy is ignored (busy still lasts 8 cycles).
- Assert rst_n=0 at clear cycle 4 → busy=0 immediately, no clr_done, all registers 0.
